// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-port responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } dmem_state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Wide enough for WAIT_CYCLES up to 7.
  localparam int WAITW = 3;

endpackage

// File: rtl/sram_phase_timer.sv
// Down-counter timing one SRAM half access: reloads WAIT_CYCLES at phase start,
// flags the final cycle (count 0) and the cycle before it (count 1).
module sram_phase_timer
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic phase_last_o,
  output logic phase_penult_o
);

  logic [WAITW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = WAITW'(WAIT_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign phase_last_o   = (count_q == '0);
  assign phase_penult_o = (count_q == WAITW'(1));

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage responder: splits each 32-bit load/store into two 16-bit SRAM
// accesses (low half, then high half) and stalls the pipeline until done.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int SRAM_AW     = 11,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               stall,
  output logic               misalign,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we,
  output logic               sram_oe,
  inout  wire  [15:0]        sram_data
);

  localparam int   IW       = SRAM_AW - 1;
  localparam logic WE_FIRST = (WAIT_CYCLES == 0);

  dmem_state_t        state_q;
  logic               we_q;
  logic [IW-1:0]      idx_q;
  logic [31:0]        wdata_q;
  logic               mis_q;
  logic [15:0]        lo_q;
  logic               drive_q;
  logic               resp_valid_q;
  logic [31:0]        resp_rdata_q;
  logic               misalign_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic               sram_we_q;
  logic               sram_oe_q;

  logic          accept;
  logic          phase_start;
  logic          phase_last;
  logic          phase_penult;
  logic [IW-1:0] req_idx;
  logic          unused_addr;

  // Upper address bits alias onto the same SRAM words.
  assign req_idx     = req_addr[SRAM_AW:2];
  assign unused_addr = ^req_addr[31:SRAM_AW+1];

  assign accept      = (state_q == IDLE) && req_valid;
  assign phase_start = accept || ((state_q == LO) && phase_last);
  assign stall       = accept || (state_q == LO) || (state_q == HI);

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .start_i        (phase_start),
    .phase_last_o   (phase_last),
    .phase_penult_o (phase_penult)
  );

  // The write strobe is registered, so it is raised one cycle ahead of the
  // phase's final cycle (or straight away when a phase is a single cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      mis_q        <= 1'b0;
      lo_q         <= '0;
      drive_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      misalign_q   <= 1'b0;
      sram_addr_q  <= '0;
      sram_we_q    <= 1'b0;
      sram_oe_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q     <= LO;
            we_q        <= req_we;
            idx_q       <= req_idx;
            wdata_q     <= req_wdata;
            mis_q       <= (req_addr[1:0] != 2'b00);
            sram_addr_q <= {req_idx, HALF_LO};
            sram_we_q   <= req_we & WE_FIRST;
            sram_oe_q   <= ~req_we;
            drive_q     <= req_we;
          end
        end
        LO: begin
          if (phase_last) begin
            state_q     <= HI;
            sram_addr_q <= {idx_q, HALF_HI};
            sram_we_q   <= we_q & WE_FIRST;
            if (!we_q) lo_q <= sram_data;
          end else begin
            sram_we_q <= we_q & phase_penult;
          end
        end
        HI: begin
          if (phase_last) begin
            state_q      <= DONE;
            sram_we_q    <= 1'b0;
            sram_oe_q    <= 1'b0;
            drive_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            misalign_q   <= mis_q;
            if (!we_q) resp_rdata_q <= {sram_data, lo_q};
          end else begin
            sram_we_q <= we_q & phase_penult;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sram_data  = drive_q ? ((sram_addr_q[0] == HALF_HI) ? wdata_q[31:16] : wdata_q[15:0])
                              : 16'hzzzz;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign misalign   = misalign_q;
  assign sram_addr  = sram_addr_q;
  assign sram_we    = sram_we_q;
  assign sram_oe    = sram_oe_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: SRAM model on the bus, word-level reference model
// checked every cycle, plus directed transactions with literal expectations.
module tb_dmem_responder;

  localparam int W  = 1;
  localparam int P  = W + 1;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          stall;
  logic          misalign;
  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic          sram_oe;
  wire  [15:0]   sram_data;

  dmem_responder #(.SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .stall      (stall),
    .misalign   (misalign),
    .sram_addr  (sram_addr),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe),
    .sram_data  (sram_data)
  );

  always #5 clk = ~clk;

  // Asynchronous-read SRAM with synchronous write.
  logic [15:0] sram_mem [2**AW];
  always @(posedge clk) if (sram_we) sram_mem[sram_addr] <= sram_data;
  assign sram_data = sram_oe ? sram_mem[sram_addr] : 16'hzzzz;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // Word-level reference memory, written when a store completes.
  logic [31:0] ref_mem [1024];

  // Per-cycle reference: position within a transaction, counted from the accept cycle.
  initial begin
    int          off = -1;
    int          cur;
    logic        in_ph, hi, done;
    logic        m_we = 1'b0, m_mis = 1'b0;
    logic [9:0]  m_idx = '0;
    logic [31:0] m_wd = '0, m_rd = '0;
    logic [10:0] m_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        off = -1; m_rd = '0; m_addr = '0;
        check("rst_stall", stall, req_valid);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_misalign", misalign, 0);
        check("rst_we", sram_we, 0);
        check("rst_oe", sram_oe, 0);
        check("rst_addr", sram_addr, 0);
      end else begin
        cur = off;
        if (off < 0 && req_valid) begin
          cur = 0;
          m_we = req_we; m_idx = req_addr[11:2]; m_wd = req_wdata;
          m_mis = (req_addr[1:0] != 2'b00);
        end
        in_ph = (cur >= 1) && (cur <= 2*P);
        hi    = cur > P;
        done  = (cur == 2*P + 1);
        if (in_ph) m_addr = {m_idx, hi};
        if (done && !m_we) m_rd = ref_mem[m_idx];
        if (done && m_we) ref_mem[m_idx] = m_wd;
        check("stall", stall, (cur == 0) || in_ph);
        check("resp_valid", resp_valid, done);
        check("misalign", misalign, done && m_mis);
        check("sram_oe", sram_oe, in_ph && !m_we);
        check("sram_we", sram_we, in_ph && m_we && ((cur - 1) % P == P - 1));
        check("sram_addr", sram_addr, m_addr);
        check("resp_rdata", resp_rdata, m_rd);
        if (in_ph && m_we) check("sram_data", sram_data, hi ? m_wd[31:16] : m_wd[15:0]);
        off = (cur < 0 || done) ? -1 : cur + 1;
      end
    end
  end

  logic [10:0] we_addr [4];
  logic [15:0] we_data [4];

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic mis,
                     output int stalls, output int wes, output int oes, output int lat);
    logic got = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    stalls = 0; wes = 0; oes = 0; lat = -1; rd = '0; mis = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (sram_we) begin
        if (wes < 4) begin we_addr[wes] = sram_addr; we_data[wes] = sram_data; end
        wes++;
      end
      if (sram_oe) oes++;
      if (resp_valid) begin got = 1'b1; lat = c; rd = resp_rdata; mis = misalign; end
    end
    check("txn_completed", got, 1);
    @(posedge clk); #1;
    $display("txn we=%0d addr=%08h wdata=%08h rdata=%08h mis=%0d lat=%0d stalls=%0d",
             we, a, d, rd, mis, lat, stalls);
  endtask

  initial begin
    logic [31:0] rd, r;
    logic        mis;
    int          st, wes, oes, lat;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Store 0x10 = DEADBEEF
    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, mis, st, wes, oes, lat);
    check("st_stalls", st, 5);
    check("st_lat", lat, 5);
    check("st_we_pulses", wes, 2);
    check("st_oe_cycles", oes, 0);
    check("st_addr_lo", we_addr[0], 8);
    check("st_addr_hi", we_addr[1], 9);
    check("st_data_lo", we_data[0], 16'hBEEF);
    check("st_data_hi", we_data[1], 16'hDEAD);
    idle(1);

    txn(1'b0, 32'h0000_0010, 32'h0, rd, mis, st, wes, oes, lat);
    check("ld_rdata", rd, 32'hDEAD_BEEF);
    check("ld_oe_cycles", oes, 4);
    check("ld_we_pulses", wes, 0);
    check("ld_misalign", mis, 0);
    idle(1);

    // Back-to-back with req_valid held high across DONE
    txn(1'b1, 32'h0000_0014, 32'h1234_5678, rd, mis, st, wes, oes, lat);
    check("b2b_st_lat", lat, 5);
    txn(1'b0, 32'h0000_0014, 32'h0, rd, mis, st, wes, oes, lat);
    check("b2b_ld_lat", lat, 5);
    check("b2b_ld_rdata", rd, 32'h1234_5678);
    idle(1);

    txn(1'b0, 32'h0000_0012, 32'h0, rd, mis, st, wes, oes, lat);
    check("mis_rdata", rd, 32'hDEAD_BEEF);
    check("mis_flag", mis, 1);
    txn(1'b0, 32'h0000_1010, 32'h0, rd, mis, st, wes, oes, lat);
    check("alias_rdata", rd, 32'hDEAD_BEEF);
    check("alias_flag", mis, 0);

    // Reset pulled low in the first HI cycle of a store
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_stall", stall, 1);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("abort_stall", stall, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_rdata", resp_rdata, 0);
    check("abort_we", sram_we, 0);
    check("abort_oe", sram_oe, 0);
    check("abort_addr", sram_addr, 0);
    @(posedge clk); #1 rst = 1'b1;
    idle(1);
    txn(1'b1, 32'h0000_0020, 32'hCAFE_F00D, rd, mis, st, wes, oes, lat);
    check("post_rst_lat", lat, 5);
    check("post_rst_stalls", st, 5);
    txn(1'b0, 32'h0000_0020, 32'h0, rd, mis, st, wes, oes, lat);
    check("post_rst_rdata", rd, 32'hCAFE_F00D);

    // Fill words 0..15, then random traffic over them with aliasing and misalignment
    for (int i = 0; i < 16; i++) begin
      txn(1'b1, i * 4, $urandom, rd, mis, st, wes, oes, lat);
    end
    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      txn(1'($urandom_range(0, 1)), (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2),
          $urandom, rd, mis, st, wes, oes, lat);
      check("rand_lat", lat, 2*P + 1);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data port.
- Accepts 32-bit load/store requests from the EX/MEM register and services each as two 16-bit accesses to the 2K×16 data SRAM over its bidirectional bus: low half first, then high half.
- Holds the pipeline with `stall` until the access completes, then returns load data with a one-cycle `resp_valid` pulse.

Parameters:
- `SRAM_AW`, 11: SRAM half-word address width.
- `WAIT_CYCLES`, 1: extra SRAM cycles per half access. Legal range 0–7.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low. Asserted when rst=0.
- `req_valid`, in, 1: MEM-stage access request. Held stable by the pipeline while `stall`=1.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data.
- `resp_valid`, out, 1: one-cycle completion pulse.
- `resp_rdata`, out, 32: last completed load data.
- `stall`, out, 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `misalign`, out, 1: pulses with `resp_valid` when `req_addr[1:0]`≠0.
- `sram_addr`, out, SRAM_AW: SRAM half-word address.
- `sram_we`, out, 1: SRAM write strobe.
- `sram_oe`, out, 1: SRAM output enable.
- `sram_data`, inout, 16: SRAM data bus. Driven only on writes, Z otherwise.

Behaviour:
- Address mapping:
  - word index = `req_addr[SRAM_AW:2]`.
  - low half `sram_addr` = {index, 1'b0}; high half = {index, 1'b1}.
  - `req_addr[1:0]` is ignored for the access and reported via `misalign`.
  - Upper address bits are ignored, so addresses alias (wrap-around).
- FSM states: IDLE, LO, HI, DONE.
  - IDLE → LO when `req_valid`=1. In that cycle `req_we`, the word index, `req_wdata` and the misalign flag are captured, and `stall`=1.
  - LO lasts WAIT_CYCLES+1 cycles, counted by the phase timer, then → HI.
  - HI lasts WAIT_CYCLES+1 cycles, then → DONE.
  - DONE lasts one cycle: `resp_valid`=1, `stall`=0, then → IDLE.
  - In DONE the pipeline advances. The still-present old request is never re-accepted; acceptance happens only in IDLE.
- `stall` is combinational: (IDLE & `req_valid`) | LO | HI.
- Timing:
  - Stall cycles = 2·(WAIT_CYCLES+1)+1.
  - `resp_valid` asserts in the cycle immediately after the last stall cycle.
  - Back-to-back requests: a new request is sampled in the IDLE cycle after DONE. Minimum issue interval = 2·(WAIT_CYCLES+1)+2 cycles.
- Store:
  - LO drives `sram_data` = `wdata[15:0]`; HI drives `wdata[31:16]`.
  - `sram_we`=1 only in the final cycle of each phase; address and data are stable for the whole phase.
  - `sram_oe`=0 throughout.
- Load:
  - `sram_oe`=1 for all LO/HI cycles; `sram_data` is Z.
  - The low half is captured at the end of LO and the high half at the end of HI.
  - `resp_rdata` updates at DONE entry and holds until the next load completes. A store leaves it unchanged.
- Bus rules:
  - `sram_we` and `sram_oe` are never both 1.
  - `sram_data` is Z whenever not (store & (LO|HI)).
  - `sram_addr` holds its last value in IDLE/DONE.
- Reset (async, mid-operation included):
  - state=IDLE, timer=0.
  - `resp_valid`=0, `resp_rdata`=0, `misalign`=0, `sram_we`=0, `sram_oe`=0, `sram_addr`=0.
  - `sram_data`=Z; `stall`=0 unless `req_valid`.
  - An aborted store may leave a half-written word; this is accepted.

Decomposition:
- Package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, LO, HI, DONE};
  - constants HALF_LO=1'b0, HALF_HI=1'b1;
  - localparam WAITW=3.
- Sub-module `sram_phase_timer`:
  - loads WAIT_CYCLES on phase start;
  - asserts `phase_last` when the count reaches 0;
  - async active-low reset.
- The top level holds the FSM, capture registers and tristate control.

Test Plan:
- Reset, then idle with `req_valid`=0 → `stall`=0, `resp_rdata`=0, `sram_data`=Z, `sram_we`=`sram_oe`=0.
- WAIT=1, store addr 0x0000_0010 data 0xDEAD_BEEF → `stall` high 5 cycles; `sram_addr` 8 then 9; halves 0xBEEF then 0xDEAD; `sram_we` pulses once per phase; `resp_valid` in cycle 5.
- Load 0x10 after the above → `resp_rdata`=0xDEAD_BEEF at `resp_valid`; `sram_oe`=1 for 4 cycles; bus never driven by the DUT.
- Back-to-back: store 0x14 = 0x1234_5678 then load 0x14 with `req_valid` held continuously → two distinct transactions, `resp_rdata`=0x1234_5678, no double-accept in DONE.
- Misaligned load 0x12 and aliased load 0x1010 (SRAM_AW=11) → both read word index 4; `misalign`=1 only for 0x12.
- Reset pulled low in HI of a store → outputs at reset values immediately; next request completes normally with correct latency.
